spi_tx_feeder: RTL and testbench

Byte sequencer directly upstream of the SPI serializer. Buffers bytes written by the controller logic (e.g. display/elevator status words) in a small FIFO. Groups them into fixed-length chip-select frames and drives the serializer's `onoff`/`data_in`, advancing one byte per serializer `valid` pulse. Enforces a minimum CS-high gap between frames.

---
 rtl/spi_tx_feeder.sv | 164 ++++++++++++++++
 tb/tb_spi_tx_feeder.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_feeder.sv
// rtl/spi_tx_feeder.sv - byte FIFO and chip-select framer feeding the SPI serializer
//
// Purpose: buffers controller bytes in a circular FIFO, groups them into
// FRAME_BYTES-long CS-low frames for the serializer, advances one byte per
// serializer valid pulse and holds CS high (onoff low) for at least
// GAP_CYCLES+1 cycles between frames.
//
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   wr_en, wr_data    byte write strobe and data (one byte per cycle)
//   full, level       FIFO full flag and byte count (decoded from registers)
//   overflow          one-cycle pulse when a write is dropped because full
//   onoff, data_out   serializer chip-select enable and byte being shifted
//   spi_valid         serializer byte-done pulse
//   busy              high while a frame or its trailing gap is in progress
//   frame_done        one-cycle pulse when the last byte of a frame completes
module spi_tx_feeder #(
    parameter int DEPTH       = 16,
    parameter int FRAME_BYTES = 2,
    parameter int GAP_CYCLES  = 100
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [7:0]                 wr_data,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow,
    output logic                       onoff,
    output logic [7:0]                 data_out,
    input  logic                       spi_valid,
    output logic                       busy,
    output logic                       frame_done
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);
    localparam int CW = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);

    localparam logic [LW-1:0] LEVEL_FULL  = LW'(DEPTH);
    localparam logic [LW-1:0] LEVEL_FRAME = LW'(FRAME_BYTES);
    localparam logic [CW-1:0] LAST_BYTE   = CW'(FRAME_BYTES - 1);
    localparam logic [GW-1:0] GAP_LOAD    = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] byte_cnt;
    logic [GW-1:0] gap_cnt;
    logic          wr_accept;
    logic          pop;
    logic          start_frame;
    logic          end_frame;

    assign full      = (level == LEVEL_FULL);
    // Fullness is judged on the registered level, so a same-cycle pop does
    // not make room for a write arriving while full.
    assign wr_accept = wr_en && !full;

    always_comb begin
        next_state  = state;
        pop         = 1'b0;
        start_frame = 1'b0;
        end_frame   = 1'b0;
        case (state)
            IDLE: begin
                // Only start once a whole frame is buffered, so SHIFT never
                // has to wait for data mid-frame.
                if (level >= LEVEL_FRAME) begin
                    pop         = 1'b1;
                    start_frame = 1'b1;
                    next_state  = SHIFT;
                end
            end
            SHIFT: begin
                if (spi_valid) begin
                    if (byte_cnt == LAST_BYTE) begin
                        end_frame  = 1'b1;
                        next_state = GAP;
                    end else begin
                        pop = 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // FIFO storage carries no reset: stale contents are unreachable once the
    // pointers and level are cleared.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= wr_en && full;
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_accept, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            onoff      <= 1'b0;
            data_out   <= 8'h00;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            byte_cnt   <= '0;
            gap_cnt    <= '0;
        end else begin
            state      <= next_state;
            busy       <= (next_state != IDLE);
            frame_done <= end_frame;
            if (pop) begin
                data_out <= mem[rd_ptr];
            end
            if (start_frame) begin
                onoff    <= 1'b1;
                byte_cnt <= '0;
            end else if (pop) begin
                byte_cnt <= byte_cnt + 1'b1;
            end
            if (end_frame) begin
                onoff   <= 1'b0;
                gap_cnt <= GAP_LOAD;
            end else if (state == GAP && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_tx_feeder.sv
// tb/tb_spi_tx_feeder.sv - self-checking bench for spi_tx_feeder
module tb_spi_tx_feeder;

    localparam int DEPTH       = 16;
    localparam int FRAME_BYTES = 2;
    localparam int GAP_CYCLES  = 100;
    localparam int SER_CYC     = 16;
    localparam int LW          = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic [LW-1:0] level;
    logic          overflow;
    logic          onoff;
    logic [7:0]    data_out;
    logic          spi_valid;
    logic          busy;
    logic          frame_done;

    logic          ser_en;
    logic          ser_valid;
    logic          man_valid;

    int            checks;
    int            errors;
    logic [7:0]    exp_q[$];
    logic [7:0]    obs_q[$];
    int            gap_q[$];
    int            exp_idx;
    int            obs_idx;
    int            fd_count;

    int            ser_cnt;
    int            low_len;
    logic          prev_on;
    logic          armed;
    logic          nv;

    spi_tx_feeder #(
        .DEPTH(DEPTH),
        .FRAME_BYTES(FRAME_BYTES),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .full(full),
        .level(level),
        .overflow(overflow),
        .onoff(onoff),
        .data_out(data_out),
        .spi_valid(spi_valid),
        .busy(busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    assign spi_valid = ser_en ? ser_valid : man_valid;

    // Behavioural serializer and bus monitor, sampling 2 ns after the falling
    // edge: records every byte handed over on a valid, counts frame_done
    // pulses and logs the CS-high gap length before each armed rise.
    always @(negedge clk) begin
        #2;
        if (reset) begin
            ser_cnt   = 0;
            ser_valid = 1'b0;
            prev_on   = 1'b0;
            armed     = 1'b0;
            low_len   = 0;
        end else begin
            if (ser_en && onoff) begin
                if (ser_valid) begin
                    ser_valid = 1'b0;
                    ser_cnt   = 0;
                end else if (ser_cnt == SER_CYC - 1) begin
                    ser_valid = 1'b1;
                end else begin
                    ser_cnt++;
                end
            end else begin
                ser_valid = 1'b0;
                ser_cnt   = 0;
            end
            nv = ser_en ? ser_valid : man_valid;
            if (nv && onoff) obs_q.push_back(data_out);
            if (frame_done) fd_count++;
            if (onoff && !prev_on && armed) begin
                gap_q.push_back(low_len);
                armed = 1'b0;
            end
            if (onoff) low_len = 0;
            else low_len++;
            if (frame_done) armed = 1'b1;
            prev_on = onoff;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    task automatic write_byte(input logic [7:0] b);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = b;
        exp_q.push_back(b);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (level == 0 && !busy && !onoff) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++; if (onoff !== 1'b0)      begin errors++; $display("FAIL reset_onoff got %b want 0", onoff); end
        checks++; if (data_out !== 8'h00)  begin errors++; $display("FAIL reset_data got %h want 00", data_out); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (level !== '0)        begin errors++; $display("FAIL reset_level got %0d want 0", level); end
        checks++; if (full !== 1'b0)       begin errors++; $display("FAIL reset_full got %b want 0", full); end
        checks++; if (overflow !== 1'b0)   begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single_frame;
        int fd0;
        bit ok;
        @(negedge clk);
        ser_en = 1'b1;
        fd0 = fd_count;
        write_byte(8'hA5);
        write_byte(8'h3C);
        checks++; if (onoff !== 1'b0) begin errors++; $display("FAIL single_early_onoff got %b want 0", onoff); end
        @(negedge clk);
        checks++; if (onoff !== 1'b1)      begin errors++; $display("FAIL single_onoff got %b want 1", onoff); end
        checks++; if (data_out !== 8'hA5)  begin errors++; $display("FAIL single_first_byte got %h want a5", data_out); end
        checks++; if (busy !== 1'b1)       begin errors++; $display("FAIL single_busy got %b want 1", busy); end
        checks++; if (level !== LW'(1))    begin errors++; $display("FAIL single_level got %0d want 1", level); end
        wait_drain(2000, ok);
        #4;
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout got busy=%b level=%0d want idle", busy, level); end
        checks++; if (fd_count - fd0 != 1) begin errors++; $display("FAIL single_frame_done got %0d want 1", fd_count - fd0); end
        checks++; if (data_out !== 8'h3C)  begin errors++; $display("FAIL single_data_hold got %h want 3c", data_out); end
        while (exp_idx < exp_q.size()) begin
            checks++;
            if (obs_idx >= obs_q.size()) begin errors++; $display("FAIL single_stream got none want %h", exp_q[exp_idx]); end
            else if (obs_q[obs_idx] !== exp_q[exp_idx]) begin errors++; $display("FAIL single_stream got %h want %h", obs_q[obs_idx], exp_q[exp_idx]); end
            exp_idx++; obs_idx++;
        end
        checks++; if (obs_q.size() > obs_idx) begin errors++; $display("FAIL single_extra got %0d extra bytes want 0", obs_q.size() - obs_idx); end
        obs_idx = obs_q.size();
    endtask

    task automatic test_partial_frame;
        int fd0;
        bit ok;
        bit seen_on;
        fd0 = fd_count;
        write_byte(8'h11);
        seen_on = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (onoff) seen_on = 1'b1;
        end
        checks++; if (seen_on !== 1'b0)  begin errors++; $display("FAIL partial_no_start got %b want 0", seen_on); end
        checks++; if (level !== LW'(1))  begin errors++; $display("FAIL partial_level got %0d want 1", level); end
        write_byte(8'h22);
        checks++; if (onoff !== 1'b0)    begin errors++; $display("FAIL partial_pre_onoff got %b want 0", onoff); end
        @(negedge clk);
        checks++; if (onoff !== 1'b1)    begin errors++; $display("FAIL partial_start got %b want 1", onoff); end
        checks++; if (data_out !== 8'h11) begin errors++; $display("FAIL partial_first_byte got %h want 11", data_out); end
        wait_drain(2000, ok);
        #4;
        checks++; if (!ok) begin errors++; $display("FAIL partial_timeout got busy=%b level=%0d want idle", busy, level); end
        checks++; if (fd_count - fd0 != 1) begin errors++; $display("FAIL partial_frame_done got %0d want 1", fd_count - fd0); end
        while (exp_idx < exp_q.size()) begin
            checks++;
            if (obs_idx >= obs_q.size()) begin errors++; $display("FAIL partial_stream got none want %h", exp_q[exp_idx]); end
            else if (obs_q[obs_idx] !== exp_q[exp_idx]) begin errors++; $display("FAIL partial_stream got %h want %h", obs_q[obs_idx], exp_q[exp_idx]); end
            exp_idx++; obs_idx++;
        end
        checks++; if (obs_q.size() > obs_idx) begin errors++; $display("FAIL partial_extra got %0d extra bytes want 0", obs_q.size() - obs_idx); end
        obs_idx = obs_q.size();
    endtask

    // Pointers sit at 4 on entry; the 10-byte run moves them to 14 so the
    // following 6-byte burst wraps through DEPTH-1 back to 0.
    task automatic test_back_to_back;
        int fd0;
        int g0;
        int g1;
        bit ok;
        g0 = gap_q.size();
        for (int i = 0; i < 10; i++) write_byte(8'h60 + 8'(i));
        wait_drain(5000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_prep_timeout got busy=%b level=%0d want idle", busy, level); end
        #4;
        g1  = gap_q.size();
        fd0 = fd_count;
        for (int i = 0; i < 6; i++) write_byte(8'h90 + 8'(i));
        wait_drain(5000, ok);
        #4;
        checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout got busy=%b level=%0d want idle", busy, level); end
        checks++; if (fd_count - fd0 != 3) begin errors++; $display("FAIL b2b_frames got %0d want 3", fd_count - fd0); end
        checks++; if (gap_q.size() - g1 != 3) begin errors++; $display("FAIL b2b_gap_count got %0d want 3", gap_q.size() - g1); end
        for (int i = g0; i < gap_q.size(); i++) begin
            checks++;
            if (i == g0 || i == g1) begin
                if (gap_q[i] < GAP_CYCLES + 1) begin errors++; $display("FAIL b2b_gap_min got %0d want >=%0d", gap_q[i], GAP_CYCLES + 1); end
            end else if (gap_q[i] != GAP_CYCLES + 1) begin
                errors++; $display("FAIL b2b_gap got %0d want %0d", gap_q[i], GAP_CYCLES + 1);
            end
        end
        while (exp_idx < exp_q.size()) begin
            checks++;
            if (obs_idx >= obs_q.size()) begin errors++; $display("FAIL b2b_stream got none want %h", exp_q[exp_idx]); end
            else if (obs_q[obs_idx] !== exp_q[exp_idx]) begin errors++; $display("FAIL b2b_stream got %h want %h", obs_q[obs_idx], exp_q[exp_idx]); end
            exp_idx++; obs_idx++;
        end
        checks++; if (obs_q.size() > obs_idx) begin errors++; $display("FAIL b2b_extra got %0d extra bytes want 0", obs_q.size() - obs_idx); end
        obs_idx = obs_q.size();
    endtask

    // Serializer held off: fill to DEPTH-1 while a frame is open, then pop
    // and write on the same cycle.
    task automatic test_simultaneous;
        @(negedge clk);
        ser_en = 1'b0;
        write_byte(8'h40);
        write_byte(8'h41);
        for (int i = 0; i < 14; i++) write_byte(8'h42 + 8'(i));
        checks++; if (level !== LW'(DEPTH - 1)) begin errors++; $display("FAIL simul_pre_level got %0d want %0d", level, DEPTH - 1); end
        checks++; if (data_out !== 8'h40)       begin errors++; $display("FAIL simul_pre_data got %h want 40", data_out); end
        @(negedge clk);
        wr_en     = 1'b1;
        wr_data   = 8'h50;
        man_valid = 1'b1;
        exp_q.push_back(8'h50);
        @(negedge clk);
        wr_en     = 1'b0;
        man_valid = 1'b0;
        checks++; if (level !== LW'(DEPTH - 1)) begin errors++; $display("FAIL simul_level got %0d want %0d", level, DEPTH - 1); end
        checks++; if (overflow !== 1'b0)        begin errors++; $display("FAIL simul_overflow got %b want 0", overflow); end
        checks++; if (data_out !== 8'h41)       begin errors++; $display("FAIL simul_advance got %h want 41", data_out); end
    endtask

    task automatic test_overflow;
        int fd0;
        bit ok;
        fd0 = fd_count;
        write_byte(8'h51);
        checks++; if (full !== 1'b1)        begin errors++; $display("FAIL ovf_full got %b want 1", full); end
        checks++; if (level !== LW'(DEPTH)) begin errors++; $display("FAIL ovf_level got %0d want %0d", level, DEPTH); end
        checks++; if (overflow !== 1'b0)    begin errors++; $display("FAIL ovf_accepted_pulse got %b want 0", overflow); end
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = 8'hEE;
        @(negedge clk);
        wr_en = 1'b0;
        checks++; if (overflow !== 1'b1)    begin errors++; $display("FAIL ovf_pulse got %b want 1", overflow); end
        checks++; if (level !== LW'(DEPTH)) begin errors++; $display("FAIL ovf_level_hold got %0d want %0d", level, DEPTH); end
        @(negedge clk);
        checks++; if (overflow !== 1'b0)    begin errors++; $display("FAIL ovf_one_cycle got %b want 0", overflow); end
        ser_en = 1'b1;
        wait_drain(8000, ok);
        #4;
        checks++; if (!ok) begin errors++; $display("FAIL ovf_timeout got busy=%b level=%0d want idle", busy, level); end
        checks++; if (fd_count - fd0 != 9) begin errors++; $display("FAIL ovf_frames got %0d want 9", fd_count - fd0); end
        while (exp_idx < exp_q.size()) begin
            checks++;
            if (obs_idx >= obs_q.size()) begin errors++; $display("FAIL ovf_stream got none want %h", exp_q[exp_idx]); end
            else if (obs_q[obs_idx] !== exp_q[exp_idx]) begin errors++; $display("FAIL ovf_stream got %h want %h", obs_q[obs_idx], exp_q[exp_idx]); end
            exp_idx++; obs_idx++;
        end
        checks++; if (obs_q.size() > obs_idx) begin errors++; $display("FAIL ovf_extra got %0d extra bytes want 0", obs_q.size() - obs_idx); end
        obs_idx = obs_q.size();
    endtask

    task automatic test_reset_mid_frame;
        int fd0;
        bit ok;
        @(negedge clk);
        ser_en = 1'b0;
        write_byte(8'hC1);
        write_byte(8'hC2);
        write_byte(8'hC3);
        write_byte(8'hC4);
        @(negedge clk);
        man_valid = 1'b1;
        @(negedge clk);
        man_valid = 1'b0;
        checks++; if (data_out !== 8'hC2) begin errors++; $display("FAIL rst_mid_data got %h want c2", data_out); end
        checks++; if (level !== LW'(2))   begin errors++; $display("FAIL rst_mid_level got %0d want 2", level); end
        #4;
        checks++;
        if (obs_idx >= obs_q.size()) begin errors++; $display("FAIL rst_mid_first got none want c1"); end
        else if (obs_q[obs_idx] !== 8'hC1) begin errors++; $display("FAIL rst_mid_first got %h want c1", obs_q[obs_idx]); end
        fd0 = fd_count;
        #1 reset = 1'b1;
        #1;
        checks++; if (onoff !== 1'b0)     begin errors++; $display("FAIL rst_async_onoff got %b want 0", onoff); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rst_async_data got %h want 00", data_out); end
        checks++; if (level !== '0)       begin errors++; $display("FAIL rst_async_level got %0d want 0", level); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_async_busy got %b want 0", busy); end
        @(negedge clk);
        @(negedge clk);
        reset   = 1'b0;
        exp_idx = exp_q.size();
        obs_idx = obs_q.size();
        for (int i = 0; i < 5; i++) @(negedge clk);
        #4;
        checks++; if (fd_count != fd0) begin errors++; $display("FAIL rst_no_frame_done got %0d want %0d", fd_count, fd0); end
        checks++; if (onoff !== 1'b0)  begin errors++; $display("FAIL rst_stay_idle got %b want 0", onoff); end
        ser_en = 1'b1;
        write_byte(8'hD1);
        write_byte(8'hD2);
        wait_drain(2000, ok);
        #4;
        checks++; if (!ok) begin errors++; $display("FAIL rst_after_timeout got busy=%b level=%0d want idle", busy, level); end
        checks++; if (fd_count - fd0 != 1) begin errors++; $display("FAIL rst_after_frames got %0d want 1", fd_count - fd0); end
        while (exp_idx < exp_q.size()) begin
            checks++;
            if (obs_idx >= obs_q.size()) begin errors++; $display("FAIL rst_after_stream got none want %h", exp_q[exp_idx]); end
            else if (obs_q[obs_idx] !== exp_q[exp_idx]) begin errors++; $display("FAIL rst_after_stream got %h want %h", obs_q[obs_idx], exp_q[exp_idx]); end
            exp_idx++; obs_idx++;
        end
        checks++; if (obs_q.size() > obs_idx) begin errors++; $display("FAIL rst_after_extra got %0d extra bytes want 0", obs_q.size() - obs_idx); end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_idx   = 0;
        obs_idx   = 0;
        reset     = 1'b1;
        wr_en     = 1'b0;
        wr_data   = 8'h00;
        ser_en    = 1'b0;
        man_valid = 1'b0;
        test_reset();
        test_single_frame();
        test_partial_frame();
        test_back_to_back();
        test_simultaneous();
        test_overflow();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
